// File: rtl/cr_sysio_srst_ctrl.sv
// Sysio-side soft-reset responder: turns CP0's one-cycle reset code into a counted
// core reset pulse or a pad request/acknowledge handshake, and keeps a sticky cause record.
module cr_sysio_srst_ctrl #(
  parameter int unsigned CORE_RST_CYC    = 16,
  parameter int unsigned SYS_ACK_TIMEOUT = 256,
  parameter int unsigned CNT_W           = 9
) (
  input  logic       forever_cpuclk,
  input  logic       cpurst,
  input  logic [1:0] cp0_sysio_srst,
  input  logic       pad_sysio_sys_srst_ack,
  input  logic       sysio_srst_cause_clr,
  output logic       sysio_xx_core_srst,
  output logic       sysio_pad_sys_srst_req,
  output logic       sysio_srst_done,
  output logic       sysio_cp0_srst_busy,
  output logic [2:0] sysio_srst_cause
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CORE    = 3'd1,
    SYSREQ  = 3'd2,
    SYSHOLD = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CORE_LOAD = CNT_W'(CORE_RST_CYC - 1);
  localparam logic [CNT_W-1:0] SYS_LOAD  = CNT_W'(SYS_ACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cause_q, cause_d;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the edge, independent of block order.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = sysio_srst_cause_clr ? 3'b000 : cause_q;
    unique case (state_q)
      IDLE: begin
        if (cp0_sysio_srst == 2'b01) begin
          state_d    = CORE;
          cnt_d      = CORE_LOAD;
          cause_d[0] = 1'b1;
        end else if (cp0_sysio_srst[1]) begin
          state_d    = SYSREQ;
          cnt_d      = SYS_LOAD;
          cause_d[1] = 1'b1;
        end
      end
      CORE: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      SYSREQ: begin
        // An acknowledge on the final timeout cycle still counts as a success.
        if (pad_sysio_sys_srst_ack) begin
          state_d = SYSHOLD;
        end else if (cnt_q == '0) begin
          state_d    = CORE;
          cnt_d      = CORE_LOAD;
          cause_d[2] = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SYSHOLD: state_d = SYSHOLD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sysio_xx_core_srst     = (state_q == CORE);
    sysio_pad_sys_srst_req = (state_q == SYSREQ) || (state_q == SYSHOLD);
    sysio_srst_done        = (state_q == DONE);
    sysio_cp0_srst_busy    = (state_q != IDLE);
    sysio_srst_cause       = cause_q;
  end

endmodule

// File: doc/cr_sysio_srst_ctrl.md
# cr_sysio_srst_ctrl

Sysio-side responder for the CP0 soft-reset protocol. It samples the one-cycle `cp0_sysio_srst[1:0]` value that CP0 emits once IFU and cache have quiesced. For a core reset, it drives a counted core reset pulse. For a system reset, it runs a request/acknowledge handshake with the pad/SoC, escalating to a core reset on timeout. The block sits in the always-on sysio clock domain, so its sticky reset-cause record survives the core reset it generates.

## Interface
Parameters:
- `CORE_RST_CYC`, default 16: core reset assertion length in cycles; legal range 2..2^CNT_W.
- `SYS_ACK_TIMEOUT`, default 256: cycles to wait for the pad acknowledge; legal range 2..2^CNT_W.
- `CNT_W`, default 9: down-counter width.

Ports:
- `forever_cpuclk`  in  1  the single clock.
- `cpurst`  in  1  synchronous, active-high reset.
- `cp0_sysio_srst`  in  2  soft-reset code, valid only in the cycle it is nonzero: 01 core, 10 system, 11 treated as system.
- `pad_sysio_sys_srst_ack`  in  1  SoC acknowledge of a system reset request.
- `sysio_srst_cause_clr`  in  1  clears the cause record.
- `sysio_xx_core_srst`  out  1  active-high core reset to CP0/IFU/IU/cache.
- `sysio_pad_sys_srst_req`  out  1  system reset request to the SoC.
- `sysio_srst_done`  out  1  one-cycle pulse when a core reset sequence ends.
- `sysio_cp0_srst_busy`  out  1  high whenever state ≠ IDLE.
- `sysio_srst_cause`  out  3  sticky record: bit0 core, bit1 system, bit2 ack timeout.

## Operation
FSM states are IDLE, CORE, SYSREQ, SYSHOLD and DONE. There is one `CNT_W`-bit down-counter `cnt`.

- **IDLE**
  - `cp0_sysio_srst==01` → CORE; load `cnt=CORE_RST_CYC-1`; set cause bit0.
  - `cp0_sysio_srst` = 10 or 11 → SYSREQ; load `cnt=SYS_ACK_TIMEOUT-1`; set cause bit1.
  - `cp0_sysio_srst==00` → stay in IDLE.
- **CORE**
  - `sysio_xx_core_srst=1`.
  - If `cnt==0` → DONE; otherwise decrement `cnt`.
- **SYSREQ**
  - `sysio_pad_sys_srst_req=1`.
  - Ack → SYSHOLD.
  - Else if `cnt==0` → CORE; load `cnt=CORE_RST_CYC-1`; set cause bit2.
  - Else decrement `cnt`.
  - If ack and `cnt==0` occur in the same cycle, ack wins.
- **SYSHOLD**
  - `sysio_pad_sys_srst_req` stays 1.
  - Terminal state; it is left only via `cpurst`, which the SoC drives for a system reset.
- **DONE**
  - `sysio_srst_done=1` for one cycle, then → IDLE.

Input handling:
- Any `cp0_sysio_srst` value arriving outside IDLE is ignored. It is not queued and does not change the cause record.
- Cause bits are set-only, via OR, and are never cleared by the generated core reset.
- `sysio_srst_cause_clr` zeroes all three cause bits on the next edge. If a clear and a set occur in the same cycle, the set wins for the bits being set; the other bits clear.

All outputs are registered, or decoded directly from the state register with no input-to-output combinational path.

## Timing
- **Reset:** `cpurst` sampled high → next edge forces IDLE, `cnt=0`, `sysio_xx_core_srst=0`, `sysio_pad_sys_srst_req=0`, `sysio_srst_done=0`, `sysio_cp0_srst_busy=0`, `sysio_srst_cause=000`. This applies from any state, including mid-count.
- **Core path:** with the request sampled at edge T:
  - `sysio_xx_core_srst` is high for exactly `CORE_RST_CYC` cycles, T+1 through T+CORE_RST_CYC.
  - `sysio_srst_done` is high in cycle T+CORE_RST_CYC+1.
  - A new request is accepted at edge T+CORE_RST_CYC+2 or later.
- **System path:**
  - `sysio_pad_sys_srst_req` rises at T+1.
  - An ack sampled at edge A gives SYSHOLD from A+1.
  - With no ack, the last sampling edge is T+SYS_ACK_TIMEOUT. The request drops and the core reset rises at T+SYS_ACK_TIMEOUT+1.
  - The core reset then follows the core-path timing.
- **Busy:** `sysio_cp0_srst_busy` rises at T+1 and falls in the cycle after DONE.
- **Ack outside SYSREQ:** `pad_sysio_sys_srst_ack` is ignored.

## Test plan
- Reset values: hold `cpurst` for 3 cycles, release → all outputs 0 and cause 000. Then pulse `cp0_sysio_srst=01` at T → core_srst high T+1..T+16, done pulse at T+17, cause=001, busy low at T+18.
- System reset with ack: pulse 10 at T, ack at T+5 → req high from T+1 onward, FSM in SYSHOLD, core_srst never asserted, cause=010. Then assert `cpurst` → all outputs 0.
- Ack timeout: pulse 11 with no ack → req high T+1..T+256; core_srst high T+257..T+272; done pulse at T+273; cause=110.
- Ack and timeout coincide: ack at T+256 → SYSHOLD; no core reset; cause bit2 stays 0.
- Ignored requests plus cause clear:
  - During CORE, pulse 10 → no state or cause change.
  - After DONE, assert `sysio_srst_cause_clr` → cause=000.
  - Clear and a new 01 request sampled together → cause=001.
- Reset mid-count: assert `cpurst` at count 5 of CORE → core_srst low and FSM in IDLE next cycle. A new 01 request afterward yields a full 16-cycle pulse.
